// File: rtl/ubit_accum.sv
// Unary-to-binary accumulator: counts 1s over a 2^BITWIDTH-sample window behind a valid/ready
// output register. Define UBIT_ACCUM_BIPOLAR_EN to add the registered bipolar output oBipolar.
module ubit_accum #(
    parameter int unsigned BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic                iStart,
    input  logic                iCont,
    input  logic                iEn,
    input  logic                iBit,
    input  logic                iReady,
    output logic [BITWIDTH:0]   oResult,
    output logic                oValid,
    output logic                oBusy,
    output logic                oOvf
`ifdef UBIT_ACCUM_BIPOLAR_EN
    ,
    output logic signed [BITWIDTH+1:0] oBipolar
`endif
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [BITWIDTH:0]   ones_q, ones_d;
    logic [BITWIDTH-1:0] samp_q, samp_d;
    logic [BITWIDTH:0]   result_q, result_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic [BITWIDTH:0]   final_val;
    logic                last_smp;
    logic                xfer;

`ifdef UBIT_ACCUM_BIPOLAR_EN
    localparam logic [BITWIDTH+1:0] NVal     = {2'b01, {BITWIDTH{1'b0}}};
    localparam logic [BITWIDTH+1:0] BipReset = -NVal;
    logic [BITWIDTH+1:0] bipolar_q, bipolar_d;
`endif

    assign final_val = ones_q + {{BITWIDTH{1'b0}}, iBit};
    assign last_smp  = (state_q == StRun) && iEn && (samp_q == {BITWIDTH{1'b1}});
    assign xfer      = valid_q && iReady;

    always_comb begin
        state_d  = state_q;
        ones_d   = ones_q;
        samp_d   = samp_q;
        result_d = result_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
`ifdef UBIT_ACCUM_BIPOLAR_EN
        bipolar_d = bipolar_q;
`endif
        if (xfer) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    state_d = StRun;
                    ones_d  = '0;
                    samp_d  = '0;
                end
            end
            StRun: begin
                if (last_smp) begin
                    // A result only lands if the output slot is empty or draining this edge.
                    if (!valid_q || xfer) begin
                        result_d = final_val;
                        valid_d  = 1'b1;
`ifdef UBIT_ACCUM_BIPOLAR_EN
                        bipolar_d = {final_val, 1'b0} - NVal;
`endif
                    end else begin
                        ovf_d = 1'b1;
                    end
                    ones_d = '0;
                    samp_d = '0;
                    if (!iCont) begin
                        state_d = StIdle;
                    end
                end else if (iEn) begin
                    ones_d = final_val;
                    samp_d = samp_q + {{(BITWIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = StIdle;
        endcase

        if (iClr) begin
            state_d  = StIdle;
            ones_d   = '0;
            samp_d   = '0;
            result_d = '0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
`ifdef UBIT_ACCUM_BIPOLAR_EN
            bipolar_d = BipReset;
`endif
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q  <= StIdle;
            ones_q   <= '0;
            samp_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef UBIT_ACCUM_BIPOLAR_EN
            bipolar_q <= BipReset;
`endif
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            samp_q   <= samp_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
`ifdef UBIT_ACCUM_BIPOLAR_EN
            bipolar_q <= bipolar_d;
`endif
        end
    end

    assign oResult = result_q;
    assign oValid  = valid_q;
    assign oBusy   = (state_q == StRun);
    assign oOvf    = ovf_q;
`ifdef UBIT_ACCUM_BIPOLAR_EN
    assign oBipolar = bipolar_q;
`endif

endmodule

// File: tb/tb_ubit_accum.sv
// Directed-sequence bench for ubit_accum (BITWIDTH=8) with shuffled random windows whose
// expected counts come from summing the generated stream.
module tb_ubit_accum;

    localparam int unsigned BW = 8;
    localparam int N = 2 ** BW;

    logic          iClk = 1'b0;
    logic          iRstN, iClr, iStart, iCont, iEn, iBit, iReady;
    logic [BW:0]   oResult;
    logic          oValid, oBusy, oOvf;
`ifdef UBIT_ACCUM_BIPOLAR_EN
    logic signed [BW+1:0] oBipolar;
`endif

    int checks = 0;
    int failures = 0;
    bit win[$];

    ubit_accum #(.BITWIDTH(BW)) dut (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .iClr    (iClr),
        .iStart  (iStart),
        .iCont   (iCont),
        .iEn     (iEn),
        .iBit    (iBit),
        .iReady  (iReady),
        .oResult (oResult),
        .oValid  (oValid),
        .oBusy   (oBusy),
        .oOvf    (oOvf)
`ifdef UBIT_ACCUM_BIPOLAR_EN
        ,
        .oBipolar(oBipolar)
`endif
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // Window with exactly k ones in random positions.
    task automatic make_window(input int k);
        bit t;
        int j;
        win.delete();
        for (int i = 0; i < N; i++) win.push_back(i < k);
        for (int i = N - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = win[i];
            win[i] = win[j];
            win[j] = t;
        end
    endtask

    function automatic int count_ones(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(win[i]);
        return s;
    endfunction

    task automatic send_window(input int n, input int gap_at, input int gap_len,
                               input bit cont_last);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    iEn = 1'b0;
                    iBit = 1'b1;
                    step();
                end
            end
            iEn = 1'b1;
            iBit = win[i];
            if (i == n - 1) begin
                iCont = cont_last;
                chk("busy_before_last", 32'(oBusy), 1);
            end
            step();
        end
        iEn = 1'b0;
        iBit = 1'b0;
    endtask

    task automatic start();
        iStart = 1'b1;
        step();
        iStart = 1'b0;
    endtask

    initial begin
        int k;
        int exp_cnt;
        iRstN = 1'b0; iClr = 1'b0; iStart = 1'b0; iCont = 1'b0;
        iEn = 1'b0; iBit = 1'b0; iReady = 1'b1;
        #12;
        iRstN = 1'b1;
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_result", 32'(oResult), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_ovf", 32'(oOvf), 0);
`ifdef UBIT_ACCUM_BIPOLAR_EN
        chk("rst_bipolar", 32'(oBipolar), -N);
`endif

        // 1: all ones
        iEn = 1'b1; iBit = 1'b1;   // iEn ignored while idle
        step();
        chk("idle_ignores_en", 32'(oBusy), 0);
        iEn = 1'b0;
        start();
        chk("t1_busy_after_start", 32'(oBusy), 1);
        make_window(N);
        send_window(N, -1, 0, 1'b0);
        chk("t1_valid", 32'(oValid), 1);
        chk("t1_result", 32'(oResult), N);
        chk("t1_busy", 32'(oBusy), 0);
        chk("t1_ovf", 32'(oOvf), 0);
`ifdef UBIT_ACCUM_BIPOLAR_EN
        chk("t1_bipolar", 32'(oBipolar), N);
`endif
        step();
        chk("t1_consumed", 32'(oValid), 0);
        chk("t1_result_hold", 32'(oResult), N);

        // 2: alternating stream with a 10-cycle enable gap mid-window
        win.delete();
        for (int i = 0; i < N; i++) win.push_back(i % 2 == 0);
        start();
        send_window(N, N / 2, 10, 1'b0);
        chk("t2_result", 32'(oResult), count_ones(N));
        chk("t2_valid", 32'(oValid), 1);
`ifdef UBIT_ACCUM_BIPOLAR_EN
        chk("t2_bipolar", 32'(oBipolar), 0);
`endif
        step();

        // 3: back-to-back windows, last one random
        iCont = 1'b1;
        start();
        for (int j = 0; j < 4; j++) begin
            k = (j == 0) ? 64 : (j == 1) ? 200 : (j == 2) ? 0 : int'($urandom_range(0, N));
            make_window(k);
            exp_cnt = count_ones(N);
            send_window(N, -1, 0, (j != 3));
            chk("t3_result", 32'(oResult), exp_cnt);
            chk("t3_valid", 32'(oValid), 1);
            chk("t3_busy", 32'(oBusy), (j != 3) ? 1 : 0);
`ifdef UBIT_ACCUM_BIPOLAR_EN
            chk("t3_bipolar", 32'(oBipolar), 2 * exp_cnt - N);
`endif
        end
        step();
        chk("t3_consumed", 32'(oValid), 0);

        // 4: backpressure drops the second result
        iReady = 1'b0;
        iCont = 1'b1;
        start();
        make_window(100);
        send_window(N, -1, 0, 1'b1);
        chk("t4_first_result", 32'(oResult), 100);
        chk("t4_first_ovf", 32'(oOvf), 0);
        make_window(50);
        send_window(N, -1, 0, 1'b0);
        chk("t4_result_kept", 32'(oResult), 100);
        chk("t4_valid", 32'(oValid), 1);
        chk("t4_ovf", 32'(oOvf), 1);
        chk("t4_busy", 32'(oBusy), 0);
        iReady = 1'b1;
        step();
        chk("t4_consumed", 32'(oValid), 0);
        chk("t4_result_after", 32'(oResult), 100);
        chk("t4_ovf_sticky", 32'(oOvf), 1);

        // 5: clear mid-window, then a fresh full window
        start();
        make_window(int'($urandom_range(0, N)));
        send_window(100, -1, 0, 1'b0);
        iClr = 1'b1; iStart = 1'b1; iEn = 1'b1; iBit = 1'b1;
        step();
        iClr = 1'b0; iStart = 1'b0; iEn = 1'b0; iBit = 1'b0;
        chk("t5_busy", 32'(oBusy), 0);
        chk("t5_valid", 32'(oValid), 0);
        chk("t5_ovf", 32'(oOvf), 0);
        chk("t5_result", 32'(oResult), 0);
`ifdef UBIT_ACCUM_BIPOLAR_EN
        chk("t5_bipolar", 32'(oBipolar), -N);
`endif
        start();
        make_window(N);
        send_window(N, -1, 0, 1'b0);
        chk("t5_new_result", 32'(oResult), N);
        chk("t5_new_valid", 32'(oValid), 1);
        step();

        // Random windows with random gaps
        for (int r = 0; r < 3; r++) begin
            k = int'($urandom_range(0, N));
            make_window(k);
            exp_cnt = count_ones(N);
            start();
            send_window(N, int'($urandom_range(1, N - 1)), int'($urandom_range(0, 5)), 1'b0);
            chk("rand_result", 32'(oResult), exp_cnt);
            chk("rand_valid", 32'(oValid), 1);
`ifdef UBIT_ACCUM_BIPOLAR_EN
            chk("rand_bipolar", 32'(oBipolar), 2 * exp_cnt - N);
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ubit_accum.md
Name: ubit_accum

Overview:
Downstream stage of the unary multiplier. It consumes the multiplier's unary product bitstream (mult) and converts it back to binary. It counts the 1s over a window of 2^BITWIDTH enabled samples and presents the count on a valid/ready output register. Supports single-shot or back-to-back windows, and flags results lost to backpressure.

Parameters:
BITWIDTH, 8, log2 of the window length. Window N = 2^BITWIDTH samples; result width is BITWIDTH+1.

Ports:
iClk  in  1  clock, rising edge.
iRstN  in  1  reset, asynchronous, active-low.
iClr  in  1  synchronous clear; highest priority after reset.
iStart  in  1  single-cycle pulse; starts a window when idle.
iCont  in  1  continuous mode; when 1, the next window starts immediately after the current one.
iEn  in  1  sample enable; iBit is counted only when iEn=1.
iBit  in  1  unary input bit (multiplier mult output).
iReady  in  1  downstream ready.
oResult  out  BITWIDTH+1  count of 1s in the last window, range 0..N.
oValid  out  1  oResult holds an unconsumed result.
oBusy  out  1  a window is in progress (state RUN).
oOvf  out  1  sticky: a completed result was dropped.

Behaviour:
- Reset (iRstN=0, async): state IDLE; ones counter and sample counter = 0; oResult=0; oValid=0; oBusy=0; oOvf=0.
- iClr=1 at an edge: same values as reset, applied synchronously. Overrides iStart, iEn and the handshake. Mid-window data is discarded.
- Counters:
  - ones: BITWIDTH+1 bits.
  - samp: BITWIDTH bits; the last sample is the one taken when samp = N-1.
  - Neither counter can overflow: at most N samples are counted per window.
- FSM, 2 states:
  - IDLE: oBusy=0. iStart=1 -> RUN, with ones=0 and samp=0. iBit is not sampled on the iStart cycle. iEn is ignored in IDLE.
  - RUN: oBusy=1. On each edge with iEn=1: ones += iBit; samp += 1. Edges with iEn=0 hold both counters; the window stretches.
  - Last sample (iEn=1 and samp=N-1): final = ones + iBit is computed and delivered. Then:
    - iCont=1: stay in RUN; ones and samp restart at 0, so the next sample goes into the new window with no gap cycle.
    - iCont=0: go to IDLE.
  - iStart while in RUN is ignored.
- Output handshake:
  - A transfer occurs on an edge where oValid=1 and iReady=1; oValid then clears, unless a new result loads on that same edge.
  - Delivery of final:
    - If oValid=0, or a transfer happens on the same edge: oResult <= final and oValid <= 1.
    - Otherwise: oResult is unchanged, final is dropped, and oOvf <= 1.
  - oOvf stays set until iClr or reset.
- Latency: oResult and oValid update on the same edge that samples the last bit. They are visible the cycle after the last iBit is presented.
- oResult holds its value after a transfer, until the next load.

Optional Feature:
Macro UBIT_ACCUM_BIPOLAR_EN.
- Defined:
  - Adds output oBipolar, signed, BITWIDTH+2 bits, equal to 2*oResult - N.
  - It is registered and loaded together with oResult. Reset and iClr value: -N.
  - Interprets the stream as bipolar: 0 ones -> -N, N/2 ones -> 0, N ones -> +N.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan (BITWIDTH=8, N=256, iReady=1 unless stated):
1. iStart, iEn=1, iBit=1 for 256 cycles -> one cycle after the last bit: oValid=1, oResult=256, oBusy=0, oOvf=0.
2. iBit alternating 1,0 for 256 samples, with iEn=0 for 10 cycles in the middle -> oResult=128; completion delayed by exactly 10 cycles.
3. iCont=1 with three windows of 64, 200, 0 ones -> oResult sequence 64, 200, 0. oBusy stays 1 throughout, with no gap cycles between windows.
4. iReady=0 and iCont=1 for two full windows (100 then 50 ones) -> oResult=100, oValid=1, oOvf=1; raising iReady then transfers 100.
5. iClr asserted after 100 samples -> next edge: oBusy=0, oValid=0, oOvf=0, oResult=0. A new iStart and 256 ones -> oResult=256.
6. With UBIT_ACCUM_BIPOLAR_EN: 0 ones -> oBipolar=-256; 128 ones -> 0; 256 ones -> +256.
